wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final (write-back) stage of the 64-bit five-stage CPU pipeline, fed from the memory-access stage.
- Selects either the ALU result or the loaded memory data as the register-file write value, based on the MemToReg control.
- Presents destination register, write data and write enable to the register file through a single output register stage.
- Register index 31 is the hardwired zero register (XZR); writes to it are always suppressed.

Parameters:
- DATA_W, 64, datapath width in bits.
- REG_AW, 5, register index width.
- ZERO_REG, 31, register index whose writes are suppressed.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  incoming instruction is valid; 0 = bubble.
- rd_i  input  REG_AW  destination register, instruction bits [4:0].
- mem_data_i  input  DATA_W  data loaded by the memory stage.
- alu_result_i  input  DATA_W  ALU/address result.
- mem_to_reg_i  input  1  1 = write memory data, 0 = write ALU result.
- reg_write_i  input  1  instruction writes a register.
- ld_size_i  input  2  load size: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- ld_signed_i  input  1  sign-extend sub-doubleword loads.
- wr_data_o  output  DATA_W  register-file write data.
- wr_reg_o  output  REG_AW  register-file write index.
- wr_en_o  output  1  register-file write enable.

Behaviour:
- Reset:
  - One clock, synchronous active-high reset (clk, rst).
  - While rst is high at a rising edge, wr_data_o = 0, wr_reg_o = 0 and wr_en_o = 0 after that edge.
  - Reset overrides any concurrent valid input; an instruction presented in a reset cycle is dropped.
- Latency:
  - Exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and hold until the next edge.
  - No handshake and no stall. A new input is accepted every cycle.
- Data select:
  - sel = mem_to_reg_i ? ext(mem_data_i) : alu_result_i. wr_data_o <= sel.
- Enable: wr_en_o <= valid_i & reg_write_i & (rd_i != ZERO_REG).
- wr_reg_o <= rd_i whenever not in reset, including bubbles and suppressed writes.
- wr_data_o also updates on bubbles. The register file must qualify its writes with wr_en_o only.
- Bubble: valid_i = 0 forces wr_en_o to 0 on the next cycle, regardless of reg_write_i.
- mem_to_reg_i = 1 with reg_write_i = 0 produces no write; the data output still updates.
- Extension function ext() when WB_LOAD_EXT_EN is defined (uses bits [N-1:0] of mem_data_i):
  - size 0: 8 bits.
  - size 1: 16 bits.
  - size 2: 32 bits.
  - size 3: full 64 bits, unmodified.
  - Sizes 0-2 are zero-extended when ld_signed_i = 0 and sign-extended from bit N-1 when ld_signed_i = 1.
  - The extension applies only on the mem_to_reg_i path; the ALU result is never modified.
- All logic is combinational up to the single output register; there are no other state elements.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined: sub-doubleword load extraction and extension as specified under ext() above.
- Undefined:
  - ext(x) = x, so the memory path always passes all 64 bits unchanged.
  - ld_size_i and ld_signed_i are ignored; the ports remain present but unused.

Test Plan:
- Reset: rst = 1 for 2 cycles while valid_i = 1, reg_write_i = 1, rd_i = 5, alu_result_i = 0x1234 -> outputs 0/0/0 during reset. After rst falls, the next edge gives wr_en_o = 1, wr_reg_o = 5, wr_data_o = 0x1234.
- ALU path: mem_to_reg_i = 0, alu_result_i = 0xDEADBEEF00000001, mem_data_i = 0xFFFF..., rd_i = 9 -> one cycle later wr_data_o = 0xDEADBEEF00000001, wr_reg_o = 9, wr_en_o = 1.
- Load path with WB_LOAD_EXT_EN defined:
  - mem_data_i = 0x00000000000080F0, size 0, signed -> wr_data_o = 0xFFFFFFFFFFFFFFF0.
  - Same input, size 1, unsigned -> 0x00000000000080F0.
  - Size 3 -> 0x00000000000080F0.
  - Without the macro, size 0 signed -> 0x00000000000080F0.
- XZR suppression: rd_i = 31, reg_write_i = 1, valid_i = 1 -> wr_en_o = 0, wr_reg_o = 31.
- Bubble and no-write cases:
  - valid_i = 0 with reg_write_i = 1 -> wr_en_o = 0.
  - reg_write_i = 0 with mem_to_reg_i = 1 (store-like) -> wr_en_o = 0.
- Back-to-back: three consecutive instructions to rd 1, 2, 3 with ALU results 10, 20, 30 -> outputs follow on consecutive cycles with no gaps.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU or load data and registers the register-file write port.
// Define WB_LOAD_EXT_EN to enable sub-doubleword load extraction and sign/zero extension.
module wb_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_signed_i,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [REG_AW-1:0] wr_reg_o,
  output logic              wr_en_o
);

  localparam logic [REG_AW-1:0] ZeroIdx = REG_AW'(ZERO_REG);

  logic [DATA_W-1:0] mem_ext;
  logic [DATA_W-1:0] wr_data_d, wr_data_q;
  logic [REG_AW-1:0] wr_reg_d, wr_reg_q;
  logic              wr_en_d, wr_en_q;

`ifdef WB_LOAD_EXT_EN
  always_comb begin
    mem_ext = mem_data_i;
    unique case (ld_size_i)
      2'd0: mem_ext = {{(DATA_W-8){ld_signed_i & mem_data_i[7]}}, mem_data_i[7:0]};
      2'd1: mem_ext = {{(DATA_W-16){ld_signed_i & mem_data_i[15]}}, mem_data_i[15:0]};
      2'd2: mem_ext = {{(DATA_W-32){ld_signed_i & mem_data_i[31]}}, mem_data_i[31:0]};
      2'd3: mem_ext = mem_data_i;
      default: mem_ext = mem_data_i;
    endcase
  end
`else
  // Load size/sign are don't-care when extension is compiled out.
  logic unused_ld;
  assign unused_ld = ^{ld_size_i, ld_signed_i};
  assign mem_ext   = mem_data_i;
`endif

  always_comb begin
    wr_data_d = mem_to_reg_i ? mem_ext : alu_result_i;
    wr_reg_d  = rd_i;
    // Writes to the zero register never reach the register file.
    wr_en_d   = valid_i & reg_write_i & (rd_i != ZeroIdx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_data_q <= '0;
      wr_reg_q  <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_data_q <= wr_data_d;
      wr_reg_q  <= wr_reg_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign wr_data_o = wr_data_q;
  assign wr_reg_o  = wr_reg_q;
  assign wr_en_o   = wr_en_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage; expectations come from a behavioural model
// that follows WB_LOAD_EXT_EN the same way the build does.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [4:0]  rd_i;
  logic [63:0] mem_data_i;
  logic [63:0] alu_result_i;
  logic        mem_to_reg_i;
  logic        reg_write_i;
  logic [1:0]  ld_size_i;
  logic        ld_signed_i;
  logic [63:0] wr_data_o;
  logic [4:0]  wr_reg_o;
  logic        wr_en_o;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rg;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .rd_i         (rd_i),
    .mem_data_i   (mem_data_i),
    .alu_result_i (alu_result_i),
    .mem_to_reg_i (mem_to_reg_i),
    .reg_write_i  (reg_write_i),
    .ld_size_i    (ld_size_i),
    .ld_signed_i  (ld_signed_i),
    .wr_data_o    (wr_data_o),
    .wr_reg_o     (wr_reg_o),
    .wr_en_o      (wr_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] model_ext(input logic [63:0] x, input logic [1:0] size,
                                            input logic sgn);
    logic [63:0] mask;
    logic [63:0] v;
`ifdef WB_LOAD_EXT_EN
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    v = x & mask;
    // Top kept bit is set iff (x & ~(mask >> 1)) & mask is non-zero.
    if (sgn && ((x & mask & ~(mask >> 1)) != 64'd0)) v = v | ~mask;
`else
    mask = 64'd0;
    v    = x | mask;
    if (sgn && size == 2'd3) v = x;
`endif
    return v;
  endfunction

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check5(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict its result, clock it in, then compare.
  task automatic step(input string tag, input logic r, input logic v, input logic [4:0] rd,
                      input logic [63:0] mem, input logic [63:0] alu, input logic m2r,
                      input logic rw, input logic [1:0] sz, input logic sgn);
    exp_t e;
    rst          = r;
    valid_i      = v;
    rd_i         = rd;
    mem_data_i   = mem;
    alu_result_i = alu;
    mem_to_reg_i = m2r;
    reg_write_i  = rw;
    ld_size_i    = sz;
    ld_signed_i  = sgn;
    if (r) begin
      e.data = 64'd0;
      e.rg   = 5'd0;
      e.en   = 1'b0;
    end else begin
      e.data = m2r ? model_ext(mem, sz, sgn) : alu;
      e.rg   = rd;
      e.en   = v && rw && (rd != 5'd31);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_queue: got empty expected entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check64({tag, "_data"}, wr_data_o, e.data);
      check5({tag, "_reg"}, wr_reg_o, e.rg);
      check1({tag, "_en"}, wr_en_o, e.en);
    end
  endtask

  localparam logic [63:0] Ld = 64'h0000_0000_0000_80F0;
  localparam logic [63:0] Ff = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst = 1'b1; valid_i = 1'b0; rd_i = '0; mem_data_i = '0; alu_result_i = '0;
    mem_to_reg_i = 1'b0; reg_write_i = 1'b0; ld_size_i = '0; ld_signed_i = 1'b0;
    #2;
    //    tag        rst v  rd     mem                     alu                    m2r rw sz  sgn
    step("reset0",   1, 1, 5'd5,  64'd0,                  64'h1234,              0, 1, 2'd3, 0);
    step("reset1",   1, 1, 5'd5,  64'd0,                  64'h1234,              0, 1, 2'd3, 0);
    step("post_rst", 0, 1, 5'd5,  64'd0,                  64'h1234,              0, 1, 2'd3, 0);
    step("alu",      0, 1, 5'd9,  Ff,                     64'hDEADBEEF00000001,  0, 1, 2'd0, 1);
    step("ld_b_s",   0, 1, 5'd4,  Ld,                     64'h77,                1, 1, 2'd0, 1);
    step("ld_b_u",   0, 1, 5'd4,  Ld,                     64'h77,                1, 1, 2'd0, 0);
    step("ld_h_u",   0, 1, 5'd6,  Ld,                     64'h77,                1, 1, 2'd1, 0);
    step("ld_h_s",   0, 1, 5'd6,  Ld,                     64'h77,                1, 1, 2'd1, 1);
    step("ld_w_s",   0, 1, 5'd7,  64'hABCD_EF01_8000_0000, 64'h77,               1, 1, 2'd2, 1);
    step("ld_w_u",   0, 1, 5'd7,  64'hABCD_EF01_8000_0000, 64'h77,               1, 1, 2'd2, 0);
    step("ld_d",     0, 1, 5'd8,  64'hF000_0000_0000_80F0, 64'h77,               1, 1, 2'd3, 1);
    step("alu_noext",0, 1, 5'd8,  Ld,                     64'hFFFF_0000_0000_0080, 0, 1, 2'd0, 1);
    step("xzr",      0, 1, 5'd31, 64'd0,                  64'h55,                0, 1, 2'd3, 0);
    step("bubble",   0, 0, 5'd12, 64'd0,                  64'h66,                0, 1, 2'd3, 0);
    step("store",    0, 1, 5'd13, 64'h99,                 64'h1000,              1, 0, 2'd3, 0);
    step("b2b_1",    0, 1, 5'd1,  64'd0,                  64'd10,                0, 1, 2'd3, 0);
    step("b2b_2",    0, 1, 5'd2,  64'd0,                  64'd20,                0, 1, 2'd3, 0);
    step("b2b_3",    0, 1, 5'd3,  64'd0,                  64'd30,                0, 1, 2'd3, 0);
    step("mid_rst",  1, 1, 5'd14, 64'd0,                  64'hABC,               0, 1, 2'd3, 0);
    step("recover",  0, 1, 5'd15, 64'd0,                  64'hDEF,               0, 1, 2'd3, 0);
    for (int i = 0; i < 8; i++) begin
      step("rand", 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
